matrix_row_scanner: RTL and testbench
=====================================

Name: matrix_row_scanner

Overview:
- Consumer side of the 16x16 LED-matrix row-data interface.
- Drives a 4-bit row index to a row-pattern source and captures the 16-bit column pattern the source returns.
- Drives the physical row-select and column lines with per-row dwell and inter-row blanking, then repeats frame after frame.
- Sits between any row-pattern source (game renderer or test pattern) and the matrix pins.

Parameters:
- ROWS, 16, number of matrix rows scanned per frame (1..2^ADDR_W).
- COLS, 16, column width of each row pattern.
- ADDR_W, 4, width of row index.
- DWELL, 1000, clk cycles each row is lit (>=1).
- BLANK, 4, clk cycles all rows off between rows (0 = no blank state).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  scan run; low forces idle.
- count  output  ADDR_W  registered row index presented to the row-pattern source.
- row_data  input  COLS  column pattern for row `count`; must be valid one cycle after `count` changes.
- row_sel  output  ROWS  one-hot active-high row drive; bit i lights row i.
- col_out  output  COLS  registered column drive for the lit row.
- frame_done  output  1  one-cycle pulse at the end of each completed frame.

Behaviour:
- Reset (async, rst_n=0): state IDLE; count=0, row_sel=0, col_out=0, frame_done=0; internal row_idx=0; dwell counter=0.
- States: IDLE, FETCH, CAPTURE, SHOW, BLANK.
- IDLE: outputs zero.
  - enable=1 -> FETCH with row_idx=0.
  - count loads row_idx on entry to FETCH.
- FETCH: 1 cycle; count holds row_idx; row_sel=0, col_out=0.
- CAPTURE: 1 cycle; col_out <= row_data at end of cycle.
- SHOW: row_sel = 1<<row_idx and col_out held for exactly DWELL cycles.
- BLANK: row_sel=0, col_out=0 for BLANK cycles; skipped when BLANK=0.
- Row advance:
  - Leaving BLANK (or SHOW if BLANK=0): row_idx increments.
  - Wrap ROWS-1 -> 0; frame_done=1 for exactly that transition cycle.
  - Then FETCH.
- Timing:
  - Row period = 2+DWELL+BLANK cycles; frame period = ROWS*(2+DWELL+BLANK).
  - Latency enable rise -> first row_sel=1: 3 cycles (IDLE, FETCH, CAPTURE).
- enable low in any state: next edge -> IDLE; row_sel=0, col_out=0, row_idx=0, count=0; no frame_done.
- row_sel is never multi-hot; row_sel and col_out change only in the same cycle as state entry/exit (no glitching from combinational source).
- row_data changes outside CAPTURE have no effect on col_out.
- rst_n mid-row: immediate clear to reset values; resume from row 0 when rst_n=1 and enable=1.

Optional Feature:
- Macro: MATRIX_SCAN_DBUF_EN.
- Defined: adds a ROWS x COLS shadow frame buffer and a LOAD state.
  - At each frame start (from IDLE or after wrap), LOAD sweeps count 0..ROWS-1, one per cycle, writing row_data into the buffer one cycle later (ROWS+1 cycles total).
  - FETCH/CAPTURE then read the buffer, not row_data, so the displayed frame is tear-free.
  - Frame period grows by ROWS+1 cycles.
  - frame_done still pulses at wrap, before LOAD.
  - row_sel=0 during LOAD.
- Undefined: no buffer, no LOAD; row_data is sampled live in CAPTURE as above.

Test Plan:
All scenarios use DWELL=4, BLANK=2 unless stated.
- Reset: hold rst_n=0 with enable=1, row_data=16'hFFFF -> count=0, row_sel=0, col_out=0, frame_done=0 throughout.
- First row: release reset, enable=1, source returns 16'h1000 for row 0 and 0 elsewhere:
  - row_sel=16'h0001 and col_out=16'h1000 from cycle 3 for 4 cycles.
  - Then 2 cycles of row_sel=0, col_out=0.
  - count=1 at cycle 9.
- Full frame: source returns 16'h0001<<row -> row_sel walks 0x0001..0x8000, each with col_out equal to row_sel; frame_done pulses once, 128 cycles after the first FETCH; row 0 repeats.
- Abort: drop enable during SHOW of row 5 -> next edge row_sel=0, col_out=0, count=0, no frame_done; re-enable restarts at row 0 after 3 cycles.
- BLANK=0, DWELL=1 -> row period 3 cycles; no blank gap; frame_done every 48 cycles.
- With MATRIX_SCAN_DBUF_EN: change source pattern from all-0 to all-1 while row 8 is shown -> rows 8..15 still show 0; the next frame shows 16'hFFFF on all rows.

Source files
------------

// File: rtl/matrix_row_scanner.sv
// matrix_row_scanner: consumer side of the LED-matrix row-data interface.
// Presents a row index on `count`, captures the returned column pattern and
// drives one lit row at a time with per-row dwell and inter-row blanking,
// frame after frame.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   enable       - scan run; low forces IDLE on the next edge
//   count        - registered row index presented to the pattern source
//   row_data     - column pattern for `count`, valid one cycle after it changes
//   row_sel      - registered one-hot row drive
//   col_out      - registered column drive for the lit row
//   frame_done   - one-cycle pulse on the wrap from the last row to row 0
//
// Optional build macro MATRIX_SCAN_DBUF_EN: adds a shadow frame buffer that
// is filled by a LOAD sweep at each frame start, so a frame is tear-free.
module matrix_row_scanner #(
    parameter int unsigned ROWS   = 16,
    parameter int unsigned COLS   = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DWELL  = 1000,
    parameter int unsigned BLANK  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] count,
    input  logic [COLS-1:0]   row_data,
    output logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   col_out,
    output logic              frame_done
);

    localparam int unsigned TMR_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0]  DWELL_LAST = TMR_W'(DWELL - 1);
    localparam logic [TMR_W-1:0]  BLANK_LAST = TMR_W'((BLANK == 0) ? 0 : BLANK - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SHOW,
        ST_BLANK
`ifdef MATRIX_SCAN_DBUF_EN
        , ST_LOAD
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  row_idx, row_idx_nxt;
    logic [ADDR_W-1:0]  count_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [ROWS-1:0]    row_sel_nxt;
    logic [COLS-1:0]    col_out_nxt;
    logic               frame_done_nxt;
    logic               row_end;
    logic [COLS-1:0]    cap_src;

`ifdef MATRIX_SCAN_DBUF_EN
    localparam int unsigned LD_W = $clog2(ROWS + 1);

    logic [COLS-1:0]    fbuf [ROWS];
    logic [LD_W-1:0]    load_idx, load_idx_nxt;
    logic               buf_we;
    logic [ADDR_W-1:0]  buf_waddr;

    assign cap_src = fbuf[row_idx];

    // Shadow frame buffer; contents are don't-care until the first LOAD.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            fbuf[buf_waddr] <= row_data;
        end
    end
`else
    assign cap_src = row_data;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            row_idx    <= '0;
            count      <= '0;
            tmr        <= '0;
            row_sel    <= '0;
            col_out    <= '0;
            frame_done <= 1'b0;
`ifdef MATRIX_SCAN_DBUF_EN
            load_idx   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            row_idx    <= row_idx_nxt;
            count      <= count_nxt;
            tmr        <= tmr_nxt;
            row_sel    <= row_sel_nxt;
            col_out    <= col_out_nxt;
            frame_done <= frame_done_nxt;
`ifdef MATRIX_SCAN_DBUF_EN
            load_idx   <= load_idx_nxt;
`endif
        end
    end

    // Next state and next registered output values.
    always_comb begin
        state_nxt      = state;
        row_idx_nxt    = row_idx;
        count_nxt      = count;
        tmr_nxt        = tmr;
        row_sel_nxt    = '0;
        col_out_nxt    = '0;
        frame_done_nxt = 1'b0;
        row_end        = 1'b0;
`ifdef MATRIX_SCAN_DBUF_EN
        load_idx_nxt   = load_idx;
        buf_we         = 1'b0;
        buf_waddr      = '0;
`endif

        if (!enable) begin
            state_nxt   = ST_IDLE;
            row_idx_nxt = '0;
            count_nxt   = '0;
            tmr_nxt     = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    row_idx_nxt = '0;
                    count_nxt   = '0;
                    tmr_nxt     = '0;
`ifdef MATRIX_SCAN_DBUF_EN
                    load_idx_nxt = '0;
                    state_nxt    = ST_LOAD;
`else
                    state_nxt    = ST_FETCH;
`endif
                end
`ifdef MATRIX_SCAN_DBUF_EN
                // Sweep count; row_data for index k arrives one cycle later,
                // so the write address trails the sweep by one.
                ST_LOAD: begin
                    buf_we       = (load_idx != '0);
                    buf_waddr    = ADDR_W'(load_idx - LD_W'(1));
                    load_idx_nxt = load_idx + LD_W'(1);
                    if (load_idx < LD_W'(ROWS - 1)) begin
                        count_nxt = ADDR_W'(load_idx + LD_W'(1));
                    end
                    if (load_idx == LD_W'(ROWS)) begin
                        state_nxt = ST_FETCH;
                        count_nxt = row_idx;
                    end
                end
`endif
                ST_FETCH: begin
                    state_nxt = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    row_sel_nxt = ROWS'(1) << row_idx;
                    col_out_nxt = cap_src;
                    tmr_nxt     = '0;
                    state_nxt   = ST_SHOW;
                end
                ST_SHOW: begin
                    row_sel_nxt = row_sel;
                    col_out_nxt = col_out;
                    tmr_nxt     = tmr + TMR_W'(1);
                    if (tmr == DWELL_LAST) begin
                        row_sel_nxt = '0;
                        col_out_nxt = '0;
                        tmr_nxt     = '0;
                        if (BLANK == 0) begin
                            row_end = 1'b1;
                        end else begin
                            state_nxt = ST_BLANK;
                        end
                    end
                end
                ST_BLANK: begin
                    tmr_nxt = tmr + TMR_W'(1);
                    if (tmr == BLANK_LAST) begin
                        tmr_nxt = '0;
                        row_end = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase

            // Row advance with frame wrap.
            if (row_end) begin
                state_nxt = ST_FETCH;
                if (row_idx == LAST_ROW) begin
                    row_idx_nxt    = '0;
                    frame_done_nxt = 1'b1;
`ifdef MATRIX_SCAN_DBUF_EN
                    load_idx_nxt   = '0;
                    state_nxt      = ST_LOAD;
`endif
                end else begin
                    row_idx_nxt = row_idx + ADDR_W'(1);
                end
                count_nxt = row_idx_nxt;
            end
        end
    end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Bench for matrix_row_scanner: two instances (DWELL=4/BLANK=2 and
// DWELL=1/BLANK=0) fed by a one-cycle-latency pattern source, checked
// against a cycle-position reference model of the scan schedule.
module tb_matrix_row_scanner;

    localparam int N    = 16;
    localparam int DW_A = 4;
    localparam int BL_A = 2;
    localparam int DW_B = 1;
    localparam int BL_B = 0;

    localparam int PH_FETCH = 0;
    localparam int PH_CAPT  = 1;
    localparam int PH_SHOW  = 2;
    localparam int PH_BLANK = 3;
    localparam int PH_LOAD  = 4;

`ifdef MATRIX_SCAN_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    localparam int FP_A = N * (2 + DW_A + BL_A) + (DBUF ? N + 1 : 0);
    localparam int FP_B = N * (2 + DW_B + BL_B) + (DBUF ? N + 1 : 0);

    logic        clk, rst_n, enable_a, enable_b;
    logic [3:0]  count_a, count_b;
    logic [15:0] row_data_a, row_data_b;
    logic [15:0] row_sel_a, row_sel_b, col_out_a, col_out_b;
    logic        frame_done_a, frame_done_b;

    logic [15:0] pat_a [N];
    logic [15:0] pat_b [N];
    logic [15:0] snap_a [N];
    logic [15:0] snap_b [N];
    logic [15:0] cap_a, cap_b;
    logic [3:0]  last_a, last_b;

    int n_cmp;
    int n_err;

    matrix_row_scanner #(.ROWS(16), .COLS(16), .ADDR_W(4), .DWELL(DW_A), .BLANK(BL_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a), .count(count_a), .row_data(row_data_a),
        .row_sel(row_sel_a), .col_out(col_out_a), .frame_done(frame_done_a)
    );

    matrix_row_scanner #(.ROWS(16), .COLS(16), .ADDR_W(4), .DWELL(DW_B), .BLANK(BL_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b), .count(count_b), .row_data(row_data_b),
        .row_sel(row_sel_b), .col_out(col_out_b), .frame_done(frame_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern source: answers the index seen in the previous cycle.
    always @(negedge clk) begin
        row_data_a = pat_a[last_a];
        row_data_b = pat_b[last_b];
        last_a     = count_a;
        last_b     = count_b;
    end

    // Where the scan schedule is t cycles after the IDLE cycle with enable high.
    function automatic void ref_at(input int t, input int dw, input int bl,
                                   output int row, output int ph, output bit fd, output int cnt);
        int u, rp, fp, f, g, p;
        rp  = 2 + dw + bl;
        fp  = N * rp + (DBUF ? N + 1 : 0);
        u   = t - 1;
        f   = u % fp;
        fd  = (u > 0) && (f == 0);
        row = 0;
        if (DBUF && f <= N) begin
            ph  = PH_LOAD;
            cnt = (f < N) ? f : N - 1;
        end else begin
            g   = DBUF ? f - (N + 1) : f;
            row = g / rp;
            cnt = row;
            p   = g % rp;
            if (p == 0)           ph = PH_FETCH;
            else if (p == 1)      ph = PH_CAPT;
            else if (p < 2 + dw)  ph = PH_SHOW;
            else                  ph = PH_BLANK;
        end
    endfunction

    // Expected outputs at step t; tracks which pattern value each row shows.
    task automatic model_step(input int t, input bit b, output logic [3:0] e_cnt,
                              output logic [15:0] e_sel, output logic [15:0] e_col, output logic e_fd);
        int row, ph, cnt;
        bit fd;
        ref_at(t, b ? DW_B : DW_A, b ? BL_B : BL_A, row, ph, fd, cnt);
        if (ph == PH_LOAD && cnt == 0) begin
            for (int i = 0; i < N; i++) begin
                if (b) snap_b[i] = pat_b[i];
                else   snap_a[i] = pat_a[i];
            end
        end
        if (ph == PH_FETCH) begin
            if (b) cap_b = DBUF ? snap_b[row] : pat_b[row];
            else   cap_a = DBUF ? snap_a[row] : pat_a[row];
        end
        e_cnt = 4'(cnt);
        e_sel = (ph == PH_SHOW) ? (16'(1) << row) : 16'h0;
        e_col = (ph == PH_SHOW) ? (b ? cap_b : cap_a) : 16'h0;
        e_fd  = fd;
    endtask

    // Return dut_a to IDLE, then raise enable; caller's next negedge is t=1.
    task automatic restart_a();
        enable_a = 1'b0;
        repeat (2) @(negedge clk);
        enable_a = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (count_a !== 4'h0 || row_sel_a !== 16'h0 || col_out_a !== 16'h0 || frame_done_a !== 1'b0) begin
                n_err++;
                $display("FAIL reset_a k=%0d count=%h row_sel=%h col_out=%h frame_done=%b (all must be 0)",
                         k, count_a, row_sel_a, col_out_a, frame_done_a);
            end
            n_cmp++;
            if (count_b !== 4'h0 || row_sel_b !== 16'h0 || col_out_b !== 16'h0 || frame_done_b !== 1'b0) begin
                n_err++;
                $display("FAIL reset_b k=%0d count=%h row_sel=%h col_out=%h frame_done=%b (all must be 0)",
                         k, count_b, row_sel_b, col_out_b, frame_done_b);
            end
        end
    endtask

    task automatic test_first_row();
        logic [3:0] ec; logic [15:0] es, eo; logic ef;
        for (int i = 0; i < N; i++) pat_a[i] = 16'h0;
        pat_a[0] = 16'h1000;
        rst_n = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk);
            model_step(t, 1'b0, ec, es, eo, ef);
            n_cmp++;
            if (count_a !== ec || row_sel_a !== es || col_out_a !== eo || frame_done_a !== ef) begin
                n_err++;
                $display("FAIL first_row t=%0d count=%h/%h row_sel=%h/%h col_out=%h/%h frame_done=%b/%b (got/exp)",
                         t, count_a, ec, row_sel_a, es, col_out_a, eo, frame_done_a, ef);
            end
        end
    endtask

    task automatic test_full_frame();
        logic [3:0] ec; logic [15:0] es, eo; logic ef;
        int pulses;
        pulses = 0;
        for (int i = 0; i < N; i++) pat_a[i] = 16'(1) << i;
        restart_a();
        for (int t = 1; t <= FP_A + 20; t++) begin
            @(negedge clk);
            model_step(t, 1'b0, ec, es, eo, ef);
            if (frame_done_a === 1'b1) pulses++;
            n_cmp++;
            if (count_a !== ec || row_sel_a !== es || col_out_a !== eo || frame_done_a !== ef) begin
                n_err++;
                $display("FAIL full_frame t=%0d count=%h/%h row_sel=%h/%h col_out=%h/%h frame_done=%b/%b (got/exp)",
                         t, count_a, ec, row_sel_a, es, col_out_a, eo, frame_done_a, ef);
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL full_frame_pulses got %0d exp 1", pulses);
        end
    endtask

    task automatic test_random();
        logic [3:0] ec; logic [15:0] es, eo; logic ef;
        for (int i = 0; i < N; i++) pat_a[i] = 16'($urandom);
        restart_a();
        for (int t = 1; t <= 2 * FP_A + 10; t++) begin
            @(negedge clk);
            model_step(t, 1'b0, ec, es, eo, ef);
            n_cmp++;
            if (count_a !== ec || row_sel_a !== es || col_out_a !== eo || frame_done_a !== ef) begin
                n_err++;
                $display("FAIL random t=%0d count=%h/%h row_sel=%h/%h col_out=%h/%h frame_done=%b/%b (got/exp)",
                         t, count_a, ec, row_sel_a, es, col_out_a, eo, frame_done_a, ef);
            end
            // Source changes while a row is lit must not reach col_out.
            if (es != 16'h0) pat_a[$urandom_range(0, N - 1)] = 16'($urandom);
        end
    endtask

    task automatic test_abort();
        logic [3:0] ec; logic [15:0] es, eo; logic ef;
        bit found;
        found = 1'b0;
        for (int i = 0; i < N; i++) pat_a[i] = 16'($urandom);
        restart_a();
        for (int t = 1; t <= 300 && !found; t++) begin
            @(negedge clk);
            model_step(t, 1'b0, ec, es, eo, ef);
            n_cmp++;
            if (count_a !== ec || row_sel_a !== es || col_out_a !== eo || frame_done_a !== ef) begin
                n_err++;
                $display("FAIL abort_run t=%0d count=%h/%h row_sel=%h/%h col_out=%h/%h (got/exp)",
                         t, count_a, ec, row_sel_a, es, col_out_a, eo);
            end
            if (es == 16'h0020) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL abort_reach row 5 never shown within 300 cycles");
        end
        enable_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (count_a !== 4'h0 || row_sel_a !== 16'h0 || col_out_a !== 16'h0 || frame_done_a !== 1'b0) begin
                n_err++;
                $display("FAIL abort_idle k=%0d count=%h row_sel=%h col_out=%h frame_done=%b (all must be 0)",
                         k, count_a, row_sel_a, col_out_a, frame_done_a);
            end
        end
        enable_a = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            model_step(t, 1'b0, ec, es, eo, ef);
            n_cmp++;
            if (count_a !== ec || row_sel_a !== es || col_out_a !== eo || frame_done_a !== ef) begin
                n_err++;
                $display("FAIL abort_restart t=%0d count=%h/%h row_sel=%h/%h col_out=%h/%h (got/exp)",
                         t, count_a, ec, row_sel_a, es, col_out_a, eo);
            end
        end
    endtask

    task automatic test_blank0();
        logic [3:0] ec; logic [15:0] es, eo; logic ef;
        int pulses;
        pulses = 0;
        for (int i = 0; i < N; i++) pat_b[i] = 16'($urandom);
        enable_b = 1'b1;
        for (int t = 1; t <= 3 * FP_B + 3; t++) begin
            @(negedge clk);
            model_step(t, 1'b1, ec, es, eo, ef);
            if (frame_done_b === 1'b1) pulses++;
            n_cmp++;
            if (count_b !== ec || row_sel_b !== es || col_out_b !== eo || frame_done_b !== ef) begin
                n_err++;
                $display("FAIL blank0 t=%0d count=%h/%h row_sel=%h/%h col_out=%h/%h frame_done=%b/%b (got/exp)",
                         t, count_b, ec, row_sel_b, es, col_out_b, eo, frame_done_b, ef);
            end
            if (es != 16'h0) pat_b[$urandom_range(0, N - 1)] = 16'($urandom);
        end
        n_cmp++;
        if (pulses !== 3) begin
            n_err++;
            $display("FAIL blank0_pulses got %0d exp 3", pulses);
        end
        enable_b = 1'b0;
    endtask

    task automatic test_reset_mid_row();
        logic [3:0] ec; logic [15:0] es, eo; logic ef;
        for (int i = 0; i < N; i++) pat_a[i] = 16'($urandom) | 16'h0001;
        restart_a();
        for (int t = 1; t <= FP_A / 2 + 5; t++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (count_a !== 4'h0 || row_sel_a !== 16'h0 || col_out_a !== 16'h0 || frame_done_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid count=%h row_sel=%h col_out=%h frame_done=%b (all must be 0)",
                     count_a, row_sel_a, col_out_a, frame_done_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            model_step(t, 1'b0, ec, es, eo, ef);
            n_cmp++;
            if (count_a !== ec || row_sel_a !== es || col_out_a !== eo || frame_done_a !== ef) begin
                n_err++;
                $display("FAIL reset_resume t=%0d count=%h/%h row_sel=%h/%h col_out=%h/%h (got/exp)",
                         t, count_a, ec, row_sel_a, es, col_out_a, eo);
            end
        end
    endtask

`ifdef MATRIX_SCAN_DBUF_EN
    task automatic test_dbuf();
        logic [3:0] ec; logic [15:0] es, eo; logic ef;
        bit switched;
        int fi;
        switched = 1'b0;
        fi = 0;
        for (int i = 0; i < N; i++) pat_a[i] = 16'h0;
        restart_a();
        for (int t = 1; t <= 2 * FP_A + 4; t++) begin
            @(negedge clk);
            model_step(t, 1'b0, ec, es, eo, ef);
            if (ef) fi++;
            n_cmp++;
            if (count_a !== ec || row_sel_a !== es || col_out_a !== eo || frame_done_a !== ef) begin
                n_err++;
                $display("FAIL dbuf t=%0d count=%h/%h row_sel=%h/%h col_out=%h/%h (got/exp)",
                         t, count_a, ec, row_sel_a, es, col_out_a, eo);
            end
            if (fi == 0 && es >= 16'h0100) begin
                n_cmp++;
                if (col_out_a !== 16'h0000) begin
                    n_err++;
                    $display("FAIL dbuf_tearfree t=%0d col_out=%h exp 0000", t, col_out_a);
                end
            end
            if (fi == 1 && es != 16'h0) begin
                n_cmp++;
                if (col_out_a !== 16'hFFFF) begin
                    n_err++;
                    $display("FAIL dbuf_next_frame t=%0d col_out=%h exp ffff", t, col_out_a);
                end
            end
            if (!switched && es == 16'h0100) begin
                for (int i = 0; i < N; i++) pat_a[i] = 16'hFFFF;
                switched = 1'b1;
            end
        end
    endtask
`endif

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        enable_a = 1'b1;
        enable_b = 1'b0;
        last_a   = '0;
        last_b   = '0;
        cap_a    = '0;
        cap_b    = '0;
        for (int i = 0; i < N; i++) begin
            pat_a[i]  = 16'hFFFF;
            pat_b[i]  = 16'hFFFF;
            snap_a[i] = '0;
            snap_b[i] = '0;
        end
        row_data_a = 16'hFFFF;
        row_data_b = 16'hFFFF;

        test_reset();
        test_first_row();
        test_full_frame();
        test_random();
        test_abort();
        test_blank0();
        test_reset_mid_row();
`ifdef MATRIX_SCAN_DBUF_EN
        test_dbuf();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
